// File: rtl/rv32v_lane_mem_sequencer_if.sv
// Element-group, dcache and writeback signals of the lane memory sequencer.
// slave is the sequencer's view; master is the surrounding pipeline/dcache.
interface rv32v_lane_mem_sequencer_if #(
  parameter int LANES  = 4,
  parameter int LIDX_W = 3
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_load;
  logic                  in_store;
  logic [1:0]            in_eew;
  logic [LANES-1:0]      in_lane_ena;
  logic [LANES*32-1:0]   in_addr;
  logic [LANES*32-1:0]   in_wdata;
  logic                  dmem_ren;
  logic                  dmem_wen;
  logic [31:0]           dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [3:0]            dmem_byte_en;
  logic [31:0]           dmem_rdata;
  logic                  dmem_hit;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;
  logic                  out_exception;
  logic [LIDX_W-1:0]     out_exc_lane;
  logic                  busy;

  modport slave (
    input  flush, in_valid, in_load, in_store, in_eew, in_lane_ena, in_addr, in_wdata,
           dmem_rdata, dmem_hit, out_ready,
    output in_ready, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
           out_valid, out_data, out_exception, out_exc_lane, busy
  );

  modport master (
    output flush, in_valid, in_load, in_store, in_eew, in_lane_ena, in_addr, in_wdata,
           dmem_rdata, dmem_hit, out_ready,
    input  in_ready, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_byte_en,
           out_valid, out_data, out_exception, out_exc_lane, busy
  );
endinterface

// File: rtl/rv32v_lane_mem_sequencer.sv
// Serialises enabled lanes of a vector group onto one dcache port; one cycle per lane on hit plus one result cycle.
// Requests held until dmem_hit; result held until out_ready; new groups only accepted while idle.
module rv32v_lane_mem_sequencer #(
  parameter int LANES    = 4,
  parameter int SIGN_EXT = 0,
  parameter int LIDX_W   = 3
) (
  input  logic CLK,
  input  logic nRST,
  rv32v_lane_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic                load_q;
  logic [1:0]          eew_q;
  logic [LANES-1:0]    ena_q;
  logic [LANES*32-1:0] addr_q, wdata_q, data_q;
  logic [LIDX_W-1:0]   ptr_q, exc_lane_q;
  logic                exc_q;

  logic                go_issue;
  logic [LIDX_W-1:0]   first_ptr, nxt_ptr;
  logic                nxt_found;
  logic [31:0]         cur_addr, cur_wdata, sh_rdata, ext_data;
  logic                fault, req;
  logic [3:0]          be_base;

  assign go_issue = (bus.in_load | bus.in_store) & (|bus.in_lane_ena);

  // Descending scans leave the lowest qualifying lane as the winner.
  always_comb begin
    first_ptr = '0;
    nxt_ptr   = '0;
    nxt_found = 1'b0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (bus.in_lane_ena[i]) first_ptr = LIDX_W'(i);
      if (ena_q[i] && (LIDX_W'(i) > ptr_q)) begin
        nxt_ptr   = LIDX_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_addr  = '0;
    cur_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ptr_q == LIDX_W'(i)) begin
        cur_addr  = addr_q[32*i +: 32];
        cur_wdata = wdata_q[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (eew_q)
      2'b01:   fault = cur_addr[0];
      2'b10:   fault = |cur_addr[1:0];
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

  always_comb begin
    sh_rdata = bus.dmem_rdata >> {cur_addr[1:0], 3'b000};
    case (eew_q)
      2'b00:   ext_data = (SIGN_EXT != 0) ? {{24{sh_rdata[7]}}, sh_rdata[7:0]}
                                          : {24'h0, sh_rdata[7:0]};
      2'b01:   ext_data = (SIGN_EXT != 0) ? {{16{sh_rdata[15]}}, sh_rdata[15:0]}
                                          : {16'h0, sh_rdata[15:0]};
      default: ext_data = sh_rdata;
    endcase
  end

  assign req = (state == ISSUE) & ~fault & ~bus.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nxt = go_issue ? ISSUE : RESP;
        ISSUE:   if (fault || (bus.dmem_hit && !nxt_found)) state_nxt = RESP;
        RESP:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    case (eew_q)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    bus.in_ready      = (state == IDLE);
    bus.busy          = (state != IDLE);
    bus.dmem_ren      = req & load_q;
    bus.dmem_wen      = req & ~load_q;
    bus.dmem_addr     = req ? {cur_addr[31:2], 2'b00} : 32'h0;
    bus.dmem_byte_en  = req ? (be_base << cur_addr[1:0]) : 4'h0;
    bus.dmem_wdata    = req ? (cur_wdata << {cur_addr[1:0], 3'b000}) : 32'h0;
    bus.out_valid     = (state == RESP);
    bus.out_exception = (state == RESP) & exc_q;
    bus.out_exc_lane  = (state == RESP) ? exc_lane_q : '0;
    bus.out_data      = data_q;
  end

  // A store acknowledged before a flush is not undone, so flush only drops the fault record.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      load_q     <= 1'b0;
      eew_q      <= 2'b00;
      ena_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      ptr_q      <= '0;
      exc_q      <= 1'b0;
      exc_lane_q <= '0;
    end else if (bus.flush) begin
      exc_q      <= 1'b0;
      exc_lane_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          load_q     <= bus.in_load;
          eew_q      <= bus.in_eew;
          ena_q      <= bus.in_lane_ena;
          addr_q     <= bus.in_addr;
          wdata_q    <= bus.in_wdata;
          data_q     <= '0;
          ptr_q      <= first_ptr;
          exc_q      <= 1'b0;
          exc_lane_q <= '0;
        end
        ISSUE: if (fault) begin
          exc_q      <= 1'b1;
          exc_lane_q <= ptr_q;
        end else if (bus.dmem_hit) begin
          for (int i = 0; i < LANES; i++)
            if (load_q && (ptr_q == LIDX_W'(i))) data_q[32*i +: 32] <= ext_data;
          ptr_q <= nxt_ptr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_lane_mem_sequencer.sv
// Self-checking bench for rv32v_lane_mem_sequencer (LANES=4, SIGN_EXT=1).
// Expected dcache requests are queued with the stimulus and popped against observed traffic.
module tb_rv32v_lane_mem_sequencer;
  localparam int LANES = 4;
  localparam int LIDX_W = 3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rv32v_lane_mem_sequencer_if #(.LANES(LANES), .LIDX_W(LIDX_W)) bus ();

  rv32v_lane_mem_sequencer #(.LANES(LANES), .SIGN_EXT(1), .LIDX_W(LIDX_W)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t exp_q[$];
  req_t obs_q[$];
  logic [31:0] mem [logic [31:0]];

  int errors = 0;
  int checks = 0;

  logic [LANES*32-1:0] res_data;
  logic                res_exc;
  logic [LIDX_W-1:0]   res_lane;
  logic                got_out, timeout;
  int                  unstable, busy_drop, first_valid;

  function automatic req_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
    req_t r;
    r.wen = w; r.addr = a; r.be = b; r.wdata = d;
    return r;
  endfunction

  task automatic start_group(input logic ld, input logic st, input logic [1:0] eew,
                             input logic [LANES-1:0] ena, input logic [LANES*32-1:0] addr,
                             input logic [LANES*32-1:0] wdata);
    for (int c = 0; c < 20 && !bus.in_ready; c++) @(negedge CLK);
    bus.in_valid = 1'b1; bus.in_load = ld; bus.in_store = st; bus.in_eew = eew;
    bus.in_lane_ena = ena; bus.in_addr = addr; bus.in_wdata = wdata;
  endtask

  // Serves the dcache from mem, optionally stalling one request and holding off out_ready.
  task automatic run_group(input int budget, input int wait_req, input int wait_cycles,
                           input int ready_hold);
    int n = 0;
    int stall = 0;
    int hold = ready_hold;
    req_t cur, ref_req;
    logic [LANES*32-1:0] ref_data;
    ref_req = '0; ref_data = '0;
    got_out = 0; timeout = 1; unstable = 0; busy_drop = 0; first_valid = -1;
    obs_q.delete();
    @(negedge CLK);
    bus.in_valid = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.dmem_hit = 1'b0; bus.out_ready = 1'b0;
      if (!bus.busy) busy_drop++;
      if (bus.dmem_ren || bus.dmem_wen) begin
        cur = mk(bus.dmem_wen, bus.dmem_addr, bus.dmem_byte_en, bus.dmem_wen ? bus.dmem_wdata : 32'h0);
        if (n == wait_req && stall < wait_cycles) begin
          if (stall == 0) ref_req = cur;
          else if (cur !== ref_req) unstable++;
          stall++;
        end else begin
          if (n == wait_req && wait_cycles > 0 && cur !== ref_req) unstable++;
          bus.dmem_hit = 1'b1;
          bus.dmem_rdata = mem.exists(cur.addr) ? mem[cur.addr] : 32'h0;
          obs_q.push_back(cur);
          n++;
        end
      end
      if (bus.out_valid) begin
        if (first_valid < 0) begin first_valid = c; ref_data = bus.out_data; end
        else if (bus.out_data !== ref_data) unstable++;
        if (hold > 0) hold--;
        else begin
          bus.out_ready = 1'b1; got_out = 1;
          res_data = bus.out_data; res_exc = bus.out_exception; res_lane = bus.out_exc_lane;
        end
      end
      @(negedge CLK);
      if (got_out) begin timeout = 0; break; end
    end
    bus.dmem_hit = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if ({bus.busy, bus.out_valid, bus.dmem_ren, bus.dmem_wen, bus.out_exception} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {bus.busy, bus.out_valid, bus.dmem_ren, bus.dmem_wen, bus.out_exception}); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_load_word();
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 4*i] = 32'hA0 + i;
      exp_q.push_back(mk(1'b0, 32'h100 + 4*i, 4'hF, 32'h0));
    end
    start_group(1, 0, 2'b10, 4'b1111, {32'h10C, 32'h108, 32'h104, 32'h100}, '0);
    run_group(40, -1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL word_timeout: no out_valid handshake"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL word_nreq: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e = exp_q.pop_front(); req_t o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL word_req: got %h want %h", o, e); end
    end
    exp_q.delete();
    checks++; if (first_valid != 4) begin errors++; $display("FAIL word_latency: got %0d want 4", first_valid); end
    checks++; if (res_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin errors++; $display("FAIL word_data: got %h", res_data); end
    checks++; if (res_exc !== 1'b0) begin errors++; $display("FAIL word_exc: got %b want 0", res_exc); end
  endtask

  task automatic test_load_byte_sext();
    mem[32'h200] = 32'h80FF7F11;
    exp_q.push_back(mk(1'b0, 32'h200, 4'b1000, 32'h0));
    exp_q.push_back(mk(1'b0, 32'h200, 4'b0010, 32'h0));
    start_group(1, 0, 2'b00, 4'b0101, {32'h0, 32'h201, 32'h0, 32'h203}, '0);
    run_group(40, -1, 0, 0);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL byte_nreq: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e = exp_q.pop_front(); req_t o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL byte_req: got %h want %h", o, e); end
    end
    exp_q.delete();
    checks++; if (res_data !== {32'h0, 32'h0000007F, 32'h0, 32'hFFFFFF80}) begin errors++; $display("FAIL byte_data: got %h", res_data); end
  endtask

  task automatic test_store_half();
    exp_q.push_back(mk(1'b1, 32'h300, 4'b1100, 32'hBEEF0000));
    exp_q.push_back(mk(1'b1, 32'h300, 4'b0011, 32'h0000BEEF));
    start_group(0, 1, 2'b01, 4'b0011, {32'h0, 32'h0, 32'h300, 32'h302}, {32'h0, 32'h0, 32'hBEEF, 32'hBEEF});
    run_group(40, -1, 0, 0);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL store_nreq: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e = exp_q.pop_front(); req_t o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL store_req: got %h want %h", o, e); end
    end
    exp_q.delete();
    checks++; if (res_data !== '0 || res_exc !== 1'b0) begin errors++; $display("FAIL store_out: data %h exc %b want 0/0", res_data, res_exc); end
  endtask

  task automatic test_misaligned();
    mem[32'h400] = 32'h11111111; mem[32'h404] = 32'h22222222;
    exp_q.push_back(mk(1'b0, 32'h400, 4'hF, 32'h0));
    exp_q.push_back(mk(1'b0, 32'h404, 4'hF, 32'h0));
    start_group(1, 0, 2'b10, 4'b1111, {32'h40C, 32'h406, 32'h404, 32'h400}, '0);
    run_group(40, -1, 0, 0);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL misal_nreq: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e = exp_q.pop_front(); req_t o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL misal_req: got %h want %h", o, e); end
    end
    exp_q.delete();
    checks++; if (res_exc !== 1'b1 || res_lane !== 3'd2) begin errors++; $display("FAIL misal_exc: got exc %b lane %0d want 1/2", res_exc, res_lane); end
    checks++; if (res_data !== {64'h0, 32'h22222222, 32'h11111111}) begin errors++; $display("FAIL misal_data: got %h", res_data); end
    checks++; if (bus.out_exception !== 1'b0 || bus.out_exc_lane !== '0) begin errors++; $display("FAIL misal_exc_idle: got %b/%0d want 0/0", bus.out_exception, bus.out_exc_lane); end
  endtask

  task automatic test_boundaries();
    start_group(1, 0, 2'b10, 4'b0000, '0, '0);
    run_group(20, -1, 0, 0);
    checks++; if (obs_q.size() != 0 || first_valid != 0) begin errors++; $display("FAIL noena: nreq %0d latency %0d want 0/0", obs_q.size(), first_valid); end
    checks++; if (res_exc !== 1'b0 || res_data !== '0) begin errors++; $display("FAIL noena_out: exc %b data %h want 0", res_exc, res_data); end
    start_group(1, 0, 2'b11, 4'b0100, {32'h0, 32'h500, 32'h0, 32'h0}, '0);
    run_group(20, -1, 0, 0);
    checks++; if (obs_q.size() != 0 || res_exc !== 1'b1 || res_lane !== 3'd2) begin
      errors++; $display("FAIL eew11: nreq %0d exc %b lane %0d want 0/1/2", obs_q.size(), res_exc, res_lane); end
  endtask

  task automatic test_wait_backpressure();
    for (int i = 0; i < 4; i++) mem[32'h500 + 4*i] = 32'hC0DE0000 + i;
    start_group(1, 0, 2'b10, 4'b1111, {32'h50C, 32'h508, 32'h504, 32'h500}, '0);
    run_group(40, 1, 3, 2);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL wait_nreq: got %0d want 4", obs_q.size()); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL wait_stable: got %0d changes want 0", unstable); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL wait_busy: busy low %0d cycles want 0", busy_drop); end
    checks++; if (first_valid != 7) begin errors++; $display("FAIL wait_latency: got %0d want 7", first_valid); end
    checks++; if (res_data !== {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}) begin errors++; $display("FAIL wait_data: got %h", res_data); end
  endtask

  task automatic test_flush_back_to_back();
    start_group(1, 0, 2'b10, 4'b1111, {32'h60C, 32'h608, 32'h604, 32'h600}, '0);
    @(negedge CLK); bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.dmem_hit = 1'b1; bus.dmem_rdata = 32'h5A5A0000 + c;
      @(negedge CLK);
    end
    bus.dmem_hit = 1'b0;
    checks++; if (bus.dmem_ren !== 1'b1 || bus.dmem_addr !== 32'h608) begin errors++; $display("FAIL flush_pre: ren %b addr %h want 1/608", bus.dmem_ren, bus.dmem_addr); end
    bus.flush = 1'b1; #1;
    checks++; if (bus.dmem_ren !== 1'b0) begin errors++; $display("FAIL flush_ren: got %b want 0", bus.dmem_ren); end
    @(negedge CLK); bus.flush = 1'b0;
    checks++; if ({bus.in_ready, bus.out_valid, bus.busy, bus.out_exception} !== 4'b1000) begin
      errors++; $display("FAIL flush_idle: got %b want 1000", {bus.in_ready, bus.out_valid, bus.busy, bus.out_exception}); end
    mem[32'h700] = 32'h12345678; mem[32'h704] = 32'h9ABCDEF0;
    start_group(1, 0, 2'b01, 4'b1001, {32'h706, 32'h0, 32'h0, 32'h700}, '0);
    run_group(40, -1, 0, 0);
    checks++; if (timeout || obs_q.size() != 2) begin errors++; $display("FAIL b2b_run: timeout %b nreq %0d want 0/2", timeout, obs_q.size()); end
    checks++; if (res_data !== {32'hFFFF9ABC, 64'h0, 32'h00005678}) begin errors++; $display("FAIL b2b_data: got %h", res_data); end
  endtask

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_load = 0; bus.in_store = 0; bus.in_eew = 0;
    bus.in_lane_ena = '0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.dmem_rdata = '0; bus.dmem_hit = 0; bus.out_ready = 0;
    test_reset();
    test_load_word();
    test_load_byte_sext();
    test_store_half();
    test_misaligned();
    test_boundaries();
    test_wait_backpressure();
    test_flush_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
